// File: rtl/sincos_pkg.sv
// Shared constants for the sine/cosine pipeline: fixed-point angle constants
// and the pipeline latencies.
package sincos_pkg;

    localparam int CORE_LAT = 12;
    localparam int LAT      = 13;

    // Real-to-integer cast rounds to nearest.
    function automatic longint fx_const(input real c, input int frac);
        return longint'(c * (2.0 ** frac));
    endfunction

    function automatic longint fx_pi(input int frac);
        return fx_const(3.14159265358979, frac);
    endfunction

    function automatic longint fx_two_pi(input int frac);
        return fx_const(6.28318530717959, frac);
    endfunction

    function automatic longint fx_half_pi(input int frac);
        return fx_const(1.57079632679490, frac);
    endfunction

    function automatic longint fx_4_pi(input int frac);
        return fx_const(1.27323954, frac);
    endfunction

    function automatic longint fx_4_pi2(input int frac);
        return fx_const(0.405284735, frac);
    endfunction

    function automatic longint fx_p(input int frac);
        return fx_const(0.225, frac);
    endfunction

endpackage

// File: rtl/sincos_parabola_core.sv
// One parabolic sine channel: 12 register stages. The input must already be
// reduced to [-pi, pi).
module sincos_parabola_core
    import sincos_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int FRAC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] y
);
    typedef logic signed [WIDTH-1:0]   word_t;
    typedef logic signed [2*WIDTH-1:0] prod_t;

    localparam word_t K_4_PI  = word_t'(fx_4_pi(FRAC));
    localparam word_t K_4_PI2 = word_t'(fx_4_pi2(FRAC));
    localparam word_t K_P     = word_t'(fx_p(FRAC));

    // Round-half-up of a Q.2FRAC product back to Q.FRAC.
    function automatic word_t rnd(input prod_t p);
        return word_t'(p[FRAC+WIDTH-1:FRAC]) + word_t'(p[FRAC-1]);
    endfunction

    prod_t r_xx, r_kx, r_qx, r_ee, r_pd;
    word_t r_x1, r_x2, r_xd2, r_kx2, r_xd3, r_kx3, r_q4, r_xd4, r_kx4;
    word_t r_est5, r_est6, r_e2, r_est7, r_nrm, r_est8, r_d, r_est9;
    word_t r_est10, r_p, r_est11, r_y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xx <= '0; r_kx <= '0; r_qx <= '0; r_ee <= '0; r_pd <= '0;
            r_x1 <= '0; r_x2 <= '0; r_xd2 <= '0; r_kx2 <= '0;
            r_xd3 <= '0; r_kx3 <= '0; r_q4 <= '0; r_xd4 <= '0; r_kx4 <= '0;
            r_est5 <= '0; r_est6 <= '0; r_e2 <= '0; r_est7 <= '0;
            r_nrm <= '0; r_est8 <= '0; r_d <= '0; r_est9 <= '0;
            r_est10 <= '0; r_p <= '0; r_est11 <= '0; r_y <= '0;
        end else if (en) begin
            r_xx    <= prod_t'(x) * prod_t'(x);
            r_kx    <= prod_t'(K_4_PI) * prod_t'(x);
            r_x1    <= x;
            r_x2    <= rnd(r_xx);
            r_kx2   <= rnd(r_kx);
            r_xd2   <= r_x1;
            r_qx    <= prod_t'(K_4_PI2) * prod_t'(r_x2);
            r_kx3   <= r_kx2;
            r_xd3   <= r_xd2;
            r_q4    <= rnd(r_qx);
            r_kx4   <= r_kx3;
            r_xd4   <= r_xd3;
            r_est5  <= r_xd4[WIDTH-1] ? r_kx4 + r_q4 : r_kx4 - r_q4;
            // est * |est| refinement, est delayed alongside to stay aligned
            r_ee    <= prod_t'(r_est5) * prod_t'(r_est5);
            r_est6  <= r_est5;
            r_e2    <= rnd(r_ee);
            r_est7  <= r_est6;
            r_nrm   <= r_est7[WIDTH-1] ? -r_e2 : r_e2;
            r_est8  <= r_est7;
            r_d     <= r_nrm - r_est8;
            r_est9  <= r_est8;
            r_pd    <= prod_t'(K_P) * prod_t'(r_d);
            r_est10 <= r_est9;
            r_p     <= rnd(r_pd);
            r_est11 <= r_est10;
            r_y     <= r_p + r_est11;
        end
    end

    assign y = r_y;

endmodule

// File: rtl/sincos_pipe.sv
// Pipelined sine/cosine generator: range reduction, parabolic cores, valid/tag
// delay line. Define SINCOS_COS_EN to build the cosine channel.
module sincos_pipe
    import sincos_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int FRAC  = 16,
    parameter int TAG_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] angle,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] sin,
    output logic signed [WIDTH-1:0] cos,
    output logic [TAG_W-1:0]        out_tag
);
    typedef logic signed [WIDTH-1:0] word_t;

    localparam word_t K_PI     = word_t'(fx_pi(FRAC));
    localparam word_t K_TWO_PI = word_t'(fx_two_pi(FRAC));

    // Single correction brings [-2pi, 2pi) into [-pi, pi).
    function automatic word_t wrap(input word_t v);
        if (v >= K_PI)  return v - K_TWO_PI;
        if (v < -K_PI)  return v + K_TWO_PI;
        return v;
    endfunction

    word_t              r_s_arg;
    logic [LAT-1:0]     r_valid;
    logic [TAG_W-1:0]   r_tag [LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s_arg <= '0;
            r_valid <= '0;
            for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
        end else if (en) begin
            r_s_arg  <= wrap(angle);
            r_valid  <= {r_valid[LAT-2:0], in_valid};
            r_tag[0] <= in_tag;
            for (int i = 1; i < LAT; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    assign out_valid = r_valid[LAT-1];
    assign out_tag   = r_tag[LAT-1];

    sincos_parabola_core #(.WIDTH(WIDTH), .FRAC(FRAC)) u_sin_core (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .x   (r_s_arg),
        .y   (sin)
    );

`ifdef SINCOS_COS_EN
    localparam word_t K_HALF_PI = word_t'(fx_half_pi(FRAC));

    word_t r_c_arg;
    word_t w_c_sum;

    assign w_c_sum = angle + K_HALF_PI;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    r_c_arg <= '0;
        else if (en) r_c_arg <= wrap(w_c_sum);
    end

    sincos_parabola_core #(.WIDTH(WIDTH), .FRAC(FRAC)) u_cos_core (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .x   (r_c_arg),
        .y   (cos)
    );
`else
    assign cos = '0;
`endif

endmodule
